// File: rtl/stream_min_max.sv
// rtl/stream_min_max.sv - per-frame min/max/span/count statistics over a valid/ready sample stream
module stream_min_max #(
    parameter int WIDTH = 8,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_span,
    output logic [CW-1:0]    out_count,
    output logic             out_sat,
    output logic             out_flat
);

    typedef enum logic [1:0] {EMPTY, ACC, DONE} state_t;

    localparam logic [CW-1:0] COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] COUNT_MAX = {CW{1'b1}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sat_q, sat_d;
    logic             flat_q, flat_d;
    logic             lt_min, gt_max;

    // Borrow out of a WIDTH+1-bit subtraction is the unsigned "a < b" flag.
    assign lt_min = 1'(({1'b0, in_data} - {1'b0, min_q}) >> WIDTH);
    assign gt_max = 1'(({1'b0, max_q} - {1'b0, in_data}) >> WIDTH);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        sat_d   = sat_q;
        flat_d  = flat_q;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    count_d = COUNT_ONE;
                    sat_d   = 1'b0;
                    flat_d  = 1'b1;
                    state_d = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    if (lt_min)            min_d  = in_data;
                    if (gt_max)            max_d  = in_data;
                    if (in_data != min_q)  flat_d = 1'b0;
                    if (count_q == COUNT_MAX) sat_d = 1'b1;
                    else                      count_d = count_q + COUNT_ONE;
                    if (in_last)           state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            min_q   <= '0;
            max_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
            flat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            flat_q  <= flat_d;
        end
    end

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_span  = max_q - min_q;
    assign out_count = count_q;
    assign out_sat   = sat_q;
    assign out_flat  = flat_q;

endmodule

// File: doc/stream_min_max.md
STREAM_MIN_MAX -- requirements
Module: stream_min_max

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the sample width in bits (WIDTH >= 2).
REQ-002 SHALL provide parameter CW, default 8, the sample-count width in bits (CW >= 2).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  input sample is present.
REQ-007 in_data  input  WIDTH  unsigned sample.
REQ-008 in_last  input  1  sample is the final beat of the frame; qualified by in_valid.
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 out_valid  output  1  frame result is available.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 out_min  output  WIDTH  smallest sample in the frame.
REQ-013 out_max  output  WIDTH  largest sample in the frame.
REQ-014 out_span  output  WIDTH  out_max minus out_min.
REQ-015 out_count  output  CW  number of samples in the frame, saturating.
REQ-016 out_sat  output  1  the frame count exceeded 2^CW-1.
REQ-017 out_flat  output  1  all samples in the frame were equal.

Function
REQ-018 A beat SHALL be accepted when in_valid and in_ready are both high on a rising clk edge.
REQ-019 The FSM SHALL have three states: EMPTY (no frame open), ACC (frame open), and DONE (result held).
REQ-020 in_ready SHALL be 1 in EMPTY and ACC, and 0 in DONE; out_valid SHALL be 1 only in DONE; both are registered-state decodes with no combinational path from inputs.
REQ-021 On a beat accepted in EMPTY, the block SHALL load min=max=in_data, count=1, sat=0, and flat=1.
REQ-022 After a beat accepted in EMPTY, the next state SHALL be DONE if in_last is 1, else ACC.
REQ-023 On a beat accepted in ACC, the block SHALL update min and max as follows.
- Compare in_data against min/max as unsigned, using a WIDTH+1-bit difference; the sign bit (bit WIDTH) gives "lower".
- min <= in_data if in_data < min.
- max <= in_data if in_data > max.
- flat <= 0 if in_data != min.
REQ-024 On a beat accepted in ACC, count SHALL increment, saturating at 2^CW-1; an accept while count == 2^CW-1 SHALL set sat=1 (sticky until the next frame).
REQ-025 A beat with in_last=1 accepted in ACC SHALL move the FSM to DONE; otherwise the FSM stays in ACC.
REQ-026 Latency: out_valid SHALL rise on the first clk edge after the in_last beat is accepted, i.e. one cycle.
REQ-027 In DONE, all out_* SHALL be stable until the handshake completes.
REQ-028 In DONE with out_ready=1, the FSM SHALL return to EMPTY at the next edge; no input beat is accepted in that cycle.
REQ-029 In EMPTY and ACC, out_ready SHALL be ignored; in DONE, in_valid SHALL be ignored.
REQ-030 out_span SHALL be the WIDTH-bit difference max - min (never negative, since max >= min).
REQ-031 A single-beat frame (in_last on the first beat) SHALL give min=max=sample, span=0, count=1, and flat=1.
REQ-032 Equal-to-extreme samples SHALL leave min and max unchanged.
REQ-033 Boundary values 0 and 2^WIDTH-1 SHALL be handled without wrap.

Reset
REQ-034 rst_n low SHALL asynchronously force the following, regardless of state or a partial frame, which is discarded:
- FSM to EMPTY.
- in_ready=1 and out_valid=0.
- out_min=0, out_max=0, out_span=0, out_count=0.
- out_sat=0 and out_flat=0.
REQ-035 After rst_n deasserts, the first accepted beat SHALL start a new frame.

Verification
REQ-036 Frame 5,3,9,3 (last on 9... last on final 3), WIDTH=8 -> out_valid on the cycle after the last beat; min=3, max=9, span=6, count=4, flat=0, sat=0.
REQ-037 Single beat 200 with in_last -> next cycle min=max=200, span=0, count=1, flat=1; hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0; in_valid pulses in that window are ignored.
REQ-038 Frame 0,255,0 -> min=0, max=255, span=255; frame 7,7,7 -> flat=1, span=0.
REQ-039 CW=2, frame of 5 beats -> count=3, sat=1; the next 2-beat frame -> count=2, sat=0.
REQ-040 Assert rst_n low mid-frame after beats 10,20, then run frame 50,40 -> min=40, max=50, count=2, with no trace of 10 or 20.
REQ-041 Assert out_ready together with out_valid, and in_valid continuously with random data and random in_last -> no beat is lost or double-counted; compare every frame against a reference model.
